// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decodes ALUOp/funct into the EX-stage control bundle,
// with valid/stall/flush handshake and multi-cycle mul sequencing. Optional illegal-encoding
// trap enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_ctrl_pipe #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [3:0]         ALUCtrl_o,
  output logic [1:0]         fur_slt_o,
  output logic               sra_scr_o,
  output logic               sh_o,
  output logic               be_o,
  output logic [1:0]         jump_o,
  output logic               RegWrite_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               illegal_o
);

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] fur;
    logic       scr;
    logic       sh;
    logic       be;
    logic [1:0] jump;
    logic       rw;
  } bundle_t;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  localparam logic [3:0] MulInit = 4'(MUL_LAT - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  bundle_t    bun_q;
  logic       valid_q;
  logic       busy_q;
  logic       illegal_q;

  bundle_t dec;
  logic    dec_mul;
  logic    dec_legal;
  logic    op_hi_zero;
  logic    accept;

  assign op_hi_zero = ((ALUOp_i >> 4) == '0);
  assign accept     = valid_i & ~busy_q & ~stall_i & ~flush_i;

  always_comb begin
    dec       = '0;
    dec_mul   = 1'b0;
    dec_legal = op_hi_zero;
    unique case (ALUOp_i[3:0])
      4'b0001: dec.alu = 4'b0110;
      4'b0011: begin dec.alu = 4'b0110; dec.be = 1'b1; end
      4'b0100: begin dec.alu = 4'b0010; dec.rw = 1'b1; end
      4'b0101: begin dec.alu = 4'b0001; dec.rw = 1'b1; end
      4'b0110: begin dec.alu = 4'b1111; dec.rw = 1'b1; end
      4'b0111: begin dec.fur = 2'b10; dec.rw = 1'b1; end
      4'b1000: begin dec.alu = 4'b0010; dec.rw = 1'b1; end
      4'b1001: dec.alu = 4'b0010;
      4'b1010: dec.alu = 4'b1101;
      4'b1011: begin dec.alu = 4'b1101; dec.be = 1'b1; end
      4'b1100: dec.jump = 2'b01;
      4'b1101: begin dec.jump = 2'b01; dec.rw = 1'b1; end
      4'b0010: begin
        unique case (funct_i)
          6'b100001: begin dec.alu = 4'b0010; dec.rw = 1'b1; end
          6'b100011: begin dec.alu = 4'b1001; dec.rw = 1'b1; end
          6'b100100: begin dec.alu = 4'b0000; dec.rw = 1'b1; end
          6'b100101: begin dec.alu = 4'b0001; dec.rw = 1'b1; end
          6'b101010: begin dec.alu = 4'b0111; dec.rw = 1'b1; end
          6'b000011: begin dec.fur = 2'b01; dec.rw = 1'b1; end
          6'b000111: begin dec.fur = 2'b01; dec.scr = 1'b1; dec.rw = 1'b1; end
          6'b000000: begin dec.fur = 2'b01; dec.sh = 1'b1; dec.rw = 1'b1; end
          6'b011000: begin dec.alu = 4'b1011; dec.rw = 1'b1; dec_mul = 1'b1; end
          6'b001000: dec.jump = 2'b10;
          default:   dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    // Upper ALUOp bits set make the whole encoding undefined.
    if (!dec_legal) begin
      dec     = '0;
      dec_mul = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      bun_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!stall_i) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            bun_q <= dec;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= ~dec_legal;
`else
            illegal_q <= 1'b0;
`endif
            if (dec_mul && (MUL_LAT > 1)) begin
              state_q <= StMul;
              cnt_q   <= MulInit;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            bun_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= 4'd0;
          end
        end
        StMul: begin
          if (cnt_q == 4'd1) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ALUCtrl_o  = bun_q.alu;
  assign fur_slt_o  = bun_q.fur;
  assign sra_scr_o  = bun_q.scr;
  assign sh_o       = bun_q.sh;
  assign be_o       = bun_q.be;
  assign jump_o     = bun_q.jump;
  assign RegWrite_o = bun_q.rw & valid_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: decode table streamed back-to-back, then mul,
// stall, flush and reset sequences.
module tb_alu_ctrl_pipe;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i, valid_i, stall_i, flush_i;
  logic [3:0] ALUOp_i;
  logic [5:0] funct_i;
  logic [3:0] ALUCtrl_o;
  logic [1:0] fur_slt_o, jump_o;
  logic       sra_scr_o, sh_o, be_o, RegWrite_o, valid_o, busy_o, illegal_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.MUL_LAT(3), .ALUOP_W(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ALUOp_i   (ALUOp_i),
    .funct_i   (funct_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .ALUCtrl_o (ALUCtrl_o),
    .fur_slt_o (fur_slt_o),
    .sra_scr_o (sra_scr_o),
    .sh_o      (sh_o),
    .be_o      (be_o),
    .jump_o    (jump_o),
    .RegWrite_o(RegWrite_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .illegal_o (illegal_o)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    logic [1:0] fur;
    logic       scr;
    logic       sh;
    logic       be;
    logic [1:0] jump;
    logic       rw;
    logic       ill;
  } vec_t;

  vec_t vecs[24];

  // Packed output word: {alu, fur, scr, sh, be, jump, rw, valid, busy, illegal}
  function automatic logic [14:0] pk(logic [3:0] alu, logic [1:0] fur, logic scr, logic sh,
                                     logic be, logic [1:0] jump, logic rw, logic vld,
                                     logic bsy, logic ill);
    return {alu, fur, scr, sh, be, jump, rw, vld, bsy, ill};
  endfunction

  task automatic chk(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = {ALUCtrl_o, fur_slt_o, sra_scr_o, sh_o, be_o, jump_o, RegWrite_o, valid_o, busy_o,
           illegal_o};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got alu/fur/scr/sh/be/jump/rw/v/busy/ill=%b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn);
    valid_i = v;
    ALUOp_i = op;
    funct_i = fn;
  endtask

  localparam logic [14:0] Zero = 15'd0;

  initial begin
    vecs[0]  = '{"addu",  4'b0010, 6'b100001, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{"addi",  4'b0100, 6'b000000, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{"ori",   4'b0101, 6'b000000, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{"lui",   4'b0111, 6'b000000, 4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[4]  = '{"j",     4'b1100, 6'b000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{"jr",    4'b0010, 6'b001000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0};
    vecs[6]  = '{"beq",   4'b0001, 6'b000000, 4'b0110, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{"bne",   4'b0011, 6'b000000, 4'b0110, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{"sltiu", 4'b0110, 6'b000000, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[9]  = '{"lw",    4'b1000, 6'b000000, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[10] = '{"sw",    4'b1001, 6'b000000, 4'b0010, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[11] = '{"blez",  4'b1010, 6'b000000, 4'b1101, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{"bgtz",  4'b1011, 6'b000000, 4'b1101, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{"jal",   4'b1101, 6'b000000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    vecs[14] = '{"subu",  4'b0010, 6'b100011, 4'b1001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[15] = '{"and",   4'b0010, 6'b100100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[16] = '{"or",    4'b0010, 6'b100101, 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[17] = '{"slt",   4'b0010, 6'b101010, 4'b0111, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[18] = '{"sra",   4'b0010, 6'b000011, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[19] = '{"srav",  4'b0010, 6'b000111, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[20] = '{"sll",   4'b0010, 6'b000000, 4'b0000, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0};
    vecs[21] = '{"badfn", 4'b0010, 6'b111111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    vecs[22] = '{"op1111",4'b1111, 6'b100001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    vecs[23] = '{"op0000",4'b0000, 6'b100001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};

    // Reset held two cycles with addu presented
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b1, 4'b0010, 6'b100001);
    tick(); chk("reset_c1", Zero);
    tick(); chk("reset_c2", Zero);
    rst_i = 1'b1;
    tick(); chk("addu_after_reset", pk(4'b0010, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));

    // Decode table, one instruction per cycle
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].fn);
      tick();
      chk(vecs[i].name, pk(vecs[i].alu, vecs[i].fur, vecs[i].scr, vecs[i].sh, vecs[i].be,
                           vecs[i].jump, vecs[i].rw, 1'b1, 1'b0, vecs[i].ill & TrapEn));
    end
    drive(1'b0, 4'b0000, 6'b000000);
    tick(); chk("idle_clear", Zero);

    // mul, MUL_LAT=3, then subu in the cycle valid rises
    drive(1'b1, 4'b0010, 6'b011000);
    tick(); chk("mul_t1", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    tick(); chk("mul_t2", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tick(); chk("mul_t3", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    drive(1'b1, 4'b0010, 6'b100011);
    tick(); chk("subu_after_mul", pk(4'b1001, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    tick(); chk("idle_after_subu", Zero);

    // mul stalled two cycles while busy
    drive(1'b1, 4'b0010, 6'b011000);
    tick(); chk("smul_t1", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    stall_i = 1'b1;
    tick(); chk("smul_t2", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tick(); chk("smul_t3", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    stall_i = 1'b0;
    tick(); chk("smul_t4", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    tick(); chk("smul_t5", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    // Stall holds a live valid bundle and blocks a new instruction
    stall_i = 1'b1;
    drive(1'b1, 4'b0100, 6'b000000);
    tick(); chk("stall_hold_valid", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    // Flush beats stall and drops the incoming instruction
    flush_i = 1'b1;
    tick(); chk("flush_over_stall", Zero);
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 4'b0000, 6'b000000);
    tick();

    // Flush mid-mul, then sll
    drive(1'b1, 4'b0010, 6'b011000);
    tick(); chk("fmul_t1", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    flush_i = 1'b1;
    tick(); chk("fmul_flushed", Zero);
    flush_i = 1'b0;
    drive(1'b1, 4'b0010, 6'b000000);
    tick(); chk("sll_after_flush", pk(4'b0000, 2'b01, 0, 1, 0, 2'b00, 1, 1, 0, 0));
    // Flush with a valid instruction drops it
    drive(1'b1, 4'b0010, 6'b100001);
    flush_i = 1'b1;
    tick(); chk("flush_drops_valid", Zero);
    flush_i = 1'b0;

    // Reset mid-mul
    drive(1'b1, 4'b0010, 6'b011000);
    tick(); chk("rmul_t1", pk(4'b1011, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    rst_i = 1'b0;
    tick(); chk("rmul_reset", Zero);
    rst_i = 1'b1;
    tick(); chk("rmul_stays_idle", Zero);
    drive(1'b1, 4'b0101, 6'b000000);
    tick(); chk("ori_after_reset", pk(4'b0001, 2'b00, 0, 0, 0, 2'b00, 1, 1, 0, 0));
    drive(1'b0, 4'b0000, 6'b000000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
